// File: rtl/cdb_issue_scheduler.sv
// Issue arbiter for int/mult/div/mem: zero-latency grants, one CDB slot booked per grant, no double booking.
// Define ISSUE_RR_EN for round-robin selection; default build is fixed priority div > mult > mem > int.
module cdb_issue_scheduler #(
  parameter int INT_LATENCY  = 1,
  parameter int MULT_LATENCY = 3,
  parameter int MEM_LATENCY  = 2,
  parameter int DIV_LATENCY  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_int_ready,
  input  logic                   i_mult_ready,
  input  logic                   i_div_ready,
  input  logic                   i_mem_ready,
  input  logic                   i_div_busy,
  output logic                   o_int_grant,
  output logic                   o_mult_grant,
  output logic                   o_div_grant,
  output logic                   o_mem_grant,
  output logic [DIV_LATENCY-1:0] o_cdb_resv
);
  localparam int W = DIV_LATENCY;

  // Bit a grant leaves behind: slot L-1 cycles ahead as seen from the next cycle.
  localparam logic [W-1:0] BOOK_INT  = (INT_LATENCY  >= 2) ? (W'(1) << ((INT_LATENCY  >= 2) ? INT_LATENCY  - 2 : 0)) : '0;
  localparam logic [W-1:0] BOOK_MULT = (MULT_LATENCY >= 2) ? (W'(1) << ((MULT_LATENCY >= 2) ? MULT_LATENCY - 2 : 0)) : '0;
  localparam logic [W-1:0] BOOK_DIV  = (DIV_LATENCY  >= 2) ? (W'(1) << ((DIV_LATENCY  >= 2) ? DIV_LATENCY  - 2 : 0)) : '0;
  localparam logic [W-1:0] BOOK_MEM  = (MEM_LATENCY  >= 2) ? (W'(1) << ((MEM_LATENCY  >= 2) ? MEM_LATENCY  - 2 : 0)) : '0;

  logic [W-1:0] r_cdb_resv;
  logic [W-1:0] w_book;
  logic [3:0]   w_elig;
  logic [3:0]   w_pick;
  logic [3:0]   w_grant;

  always_comb begin
    w_elig    = '0;
    w_elig[0] = i_int_ready  & ~r_cdb_resv[INT_LATENCY-1];
    w_elig[1] = i_mult_ready & ~r_cdb_resv[MULT_LATENCY-1];
    w_elig[2] = i_div_ready  & ~i_div_busy & ~r_cdb_resv[DIV_LATENCY-1];
    w_elig[3] = i_mem_ready  & ~r_cdb_resv[MEM_LATENCY-1];
  end

`ifdef ISSUE_RR_EN
  logic [1:0] r_last_grant;
  logic [1:0] w_pick_idx;
  logic       w_found;

  always_comb begin
    w_pick     = '0;
    w_pick_idx = r_last_grant;
    w_found    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] w_idx;
      w_idx = r_last_grant + 2'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_pick[w_idx] = 1'b1;
        w_pick_idx    = w_idx;
        w_found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 2'd3;
    end else if (w_found) begin
      r_last_grant <= w_pick_idx;
    end
  end
`else
  always_comb begin
    w_pick = '0;
    if (w_elig[2])      w_pick = 4'b0100;
    else if (w_elig[1]) w_pick = 4'b0010;
    else if (w_elig[3]) w_pick = 4'b1000;
    else if (w_elig[0]) w_pick = 4'b0001;
  end
`endif

  assign w_grant = w_pick & {4{rst_n}};

  always_comb begin
    w_book = '0;
    if (w_grant[0]) w_book = w_book | BOOK_INT;
    if (w_grant[1]) w_book = w_book | BOOK_MULT;
    if (w_grant[2]) w_book = w_book | BOOK_DIV;
    if (w_grant[3]) w_book = w_book | BOOK_MEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_resv <= '0;
    end else begin
      r_cdb_resv <= (r_cdb_resv >> 1) | w_book;
    end
  end

  assign o_int_grant  = w_grant[0];
  assign o_mult_grant = w_grant[1];
  assign o_div_grant  = w_grant[2];
  assign o_mem_grant  = w_grant[3];
  assign o_cdb_resv   = r_cdb_resv;

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Bench for cdb_issue_scheduler at default latencies (int=1, mult=3, div=5, mem=2); follows ISSUE_RR_EN.
module tb_cdb_issue_scheduler;
  logic       clk;
  logic       rst_n;
  logic       i_int_ready, i_mult_ready, i_div_ready, i_mem_ready, i_div_busy;
  logic       o_int_grant, o_mult_grant, o_div_grant, o_mem_grant;
  logic [4:0] o_cdb_resv;

  cdb_issue_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_int_ready  (i_int_ready),
    .i_mult_ready (i_mult_ready),
    .i_div_ready  (i_div_ready),
    .i_mem_ready  (i_mem_ready),
    .i_div_busy   (i_div_busy),
    .o_int_grant  (o_int_grant),
    .o_mult_grant (o_mult_grant),
    .o_div_grant  (o_div_grant),
    .o_mem_grant  (o_mem_grant),
    .o_cdb_resv   (o_cdb_resv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rdy;
    logic       busy;
    logic [3:0] grant;
    logic [4:0] resv;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [4:0] resv;
  } exp_t;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         lat[4] = '{1, 3, 5, 2};
  logic [4:0] m_resv;
  logic [1:0] m_last;
  exp_t       exp_q[$];
  bit         slot_used[int];
  vec_t       tbl[9];

  function automatic logic [3:0] dut_grant();
    return {o_mem_grant, o_div_grant, o_mult_grant, o_int_grant};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [3:0] model_grant(input logic [3:0] r, input logic b,
                                             input logic [4:0] rs, input logic [1:0] last);
    logic [3:0] e;
    logic [3:0] g;
    e[0] = r[0] & ~rs[lat[0]-1];
    e[1] = r[1] & ~rs[lat[1]-1];
    e[2] = r[2] & ~b & ~rs[lat[2]-1];
    e[3] = r[3] & ~rs[lat[3]-1];
    g = '0;
`ifdef ISSUE_RR_EN
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = last + 2'(k);
      if (g == 4'b0000 && e[idx]) g[idx] = 1'b1;
    end
`else
    if (last == 2'd0) g = '0;
    if (e[2])      g = 4'b0100;
    else if (e[1]) g = 4'b0010;
    else if (e[3]) g = 4'b1000;
    else if (e[0]) g = 4'b0001;
`endif
    return g;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic [3:0] r, input logic b, output logic [3:0] g_out, output logic [4:0] rs_out);
    exp_t e;
    logic [3:0] g;
    i_int_ready  = r[0];
    i_mult_ready = r[1];
    i_div_ready  = r[2];
    i_mem_ready  = r[3];
    i_div_busy   = b;
    e.grant = model_grant(r, b, m_resv, m_last);
    e.resv  = m_resv;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    g = dut_grant();
    chk("grant", 32'(g), 32'(e.grant));
    chk("resv", 32'(o_cdb_resv), 32'(e.resv));
    chk("onehot0", 32'($onehot0(g)), 32'd1);
    for (int u = 0; u < 4; u++) begin
      if (g[u]) begin
        chk("cdb_owner", 32'(slot_used.exists(cyc + lat[u])), 32'd0);
        slot_used[cyc + lat[u]] = 1'b1;
      end
    end
    g_out  = g;
    rs_out = o_cdb_resv;
    m_resv = m_resv >> 1;
    for (int u = 0; u < 4; u++) begin
      if (e.grant[u]) begin
        if (lat[u] >= 2) m_resv[lat[u]-2] = 1'b1;
        m_last = 2'(u);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_int_ready  = 1'b1;
    i_mult_ready = 1'b1;
    i_div_ready  = 1'b1;
    i_mem_ready  = 1'b1;
    i_div_busy   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_resv", 32'(o_cdb_resv), 32'd0);
    chk("rst_grant", 32'(dut_grant()), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_grant", 32'(dut_grant()), 32'd0);
    rst_n  = 1'b1;
    m_resv = '0;
    m_last = 2'd3;
    slot_used.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    logic [4:0] rs;

`ifdef ISSUE_RR_EN
    tbl[0] = '{4'b1111, 1'b0, 4'b0001, 5'b00000};
    tbl[1] = '{4'b1111, 1'b0, 4'b0010, 5'b00000};
    tbl[2] = '{4'b1111, 1'b0, 4'b0100, 5'b00010};
    tbl[3] = '{4'b1111, 1'b0, 4'b1000, 5'b01001};
    tbl[4] = '{4'b1111, 1'b1, 4'b1000, 5'b00101};
    tbl[5] = '{4'b1000, 1'b0, 4'b0000, 5'b00011};
    tbl[6] = '{4'b1000, 1'b0, 4'b1000, 5'b00001};
    tbl[7] = '{4'b0001, 1'b0, 4'b0000, 5'b00001};
    tbl[8] = '{4'b0001, 1'b0, 4'b0001, 5'b00000};
`else
    tbl[0] = '{4'b1111, 1'b0, 4'b0100, 5'b00000};
    tbl[1] = '{4'b1111, 1'b1, 4'b0010, 5'b01000};
    tbl[2] = '{4'b1111, 1'b1, 4'b0001, 5'b00110};
    tbl[3] = '{4'b1111, 1'b1, 4'b0010, 5'b00011};
    tbl[4] = '{4'b1000, 1'b0, 4'b0000, 5'b00011};
    tbl[5] = '{4'b1000, 1'b0, 4'b1000, 5'b00001};
    tbl[6] = '{4'b0001, 1'b0, 4'b0000, 5'b00001};
    tbl[7] = '{4'b0001, 1'b0, 4'b0001, 5'b00000};
    tbl[8] = '{4'b0000, 1'b0, 4'b0000, 5'b00000};
`endif

    m_resv = '0;
    m_last = 2'd3;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rdy, tbl[i].busy, g, rs);
      chk($sformatf("tbl%0d_grant", i), 32'(g), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d_resv", i), 32'(rs), 32'(tbl[i].resv));
    end

    // Div's slot blocks a later mult aimed at the same CDB cycle.
    do_reset();
    step(4'b0100, 1'b0, g, rs); chk("blk_div", 32'(g), 32'b0100);
    step(4'b0000, 1'b0, g, rs); chk("blk_idle", 32'(g), 32'b0000);
    step(4'b0010, 1'b0, g, rs); chk("blk_mult_blocked", 32'(g), 32'b0000);
    step(4'b0010, 1'b0, g, rs); chk("blk_mult_granted", 32'(g), 32'b0010);

    // Busy divider never issues; dropping busy issues it in the same cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(4'b0100, 1'b1, g, rs);
      chk("busy_hold", 32'(g), 32'b0000);
    end
    step(4'b0100, 1'b0, g, rs); chk("busy_drop", 32'(g), 32'b0100);

    // Build resv=01010, then reset mid-cycle.
    do_reset();
    step(4'b0100, 1'b0, g, rs);
    step(4'b0000, 1'b0, g, rs);
    step(4'b0100, 1'b0, g, rs);
    chk("pre_rst_resv", 32'(o_cdb_resv), 32'b01010);
    i_int_ready = 1'b1; i_mult_ready = 1'b1; i_div_ready = 1'b1; i_mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_resv", 32'(o_cdb_resv), 32'd0);
    chk("async_rst_grant", 32'(dut_grant()), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_low_resv", 32'(o_cdb_resv), 32'd0);
    rst_n  = 1'b1;
    m_resv = '0;
    m_last = 2'd3;
    slot_used.delete();
    step(4'b1000, 1'b0, g, rs); chk("post_rst_mem", 32'(g), 32'b1000);

    for (int i = 0; i < 10000; i++) begin
      step(4'($urandom), ($urandom_range(0, 3) == 0), g, rs);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
